// File: rtl/counter_pkg.sv
// Purpose: shared constants for the counter sequencer (state encoding, direction codes, default width).
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Ports: none.
package counter_pkg;

  localparam int CNT_W_DEF = 4;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  // Encoding is visible on the debug/LED output, so values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/counter_tick_gen.sv
// Purpose: prescaler that paces count steps; counts 0..PRESCALE-1 and wraps.
// Latency: o_tick is combinational from the prescaler register (asserted while it holds PRESCALE-1).
// Backpressure: none; i_hold freezes the count, i_clr (priority over hold) returns it to 0.
// Ports: i_clk, i_rst (sync, active-high), i_clr, i_hold -> o_tick.
// PRESCALE must be >= 2 so consecutive ticks are at least two cycles apart.
module counter_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_hold,
  output logic o_tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
    end
  end

  // Held prescaler never ticks, so a paused value of LAST does not fire until resumed.
  assign o_tick = !i_hold && (r_cnt == LAST);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Purpose: turns start/stop/load/dir button pulses into enable/mode/load controls for an up/down counter.
// Latency: all outputs registered; a button or tick acts on the edge after it is sampled.
// Backpressure: none; a button in the same cycle as a tick wins and that step is dropped.
// Ports: i_clk, i_rst (sync, active-high), i_btn_start/stop/load/dir, i_load_val, i_cnt_in
//        -> o_cnt_en, o_cnt_mode, o_cnt_load, o_cnt_load_val, o_tc, o_state.
// Option: COUNTER_CTRL_BOUNCE_EN makes a terminal hit reverse direction and keep running (ping-pong).
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PRESCALE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_start,
  input  logic             i_btn_stop,
  input  logic             i_btn_load,
  input  logic             i_btn_dir,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic [CNT_W-1:0] i_cnt_in,
  output logic             o_cnt_en,
  output logic             o_cnt_mode,
  output logic             o_cnt_load,
  output logic [CNT_W-1:0] o_cnt_load_val,
  output logic             o_tc,
  output logic [2:0]       o_state
);

  state_t           r_state;
  logic             r_cnt_en;
  logic             r_cnt_mode;
  logic             r_cnt_load;
  logic [CNT_W-1:0] r_cnt_load_val;
  logic             r_tc;

  state_t           w_state_nxt;
  logic             w_cnt_en_nxt;
  logic             w_cnt_mode_nxt;
  logic             w_cnt_load_nxt;
  logic [CNT_W-1:0] w_cnt_load_val_nxt;
  logic             w_tc_nxt;
  logic             w_pre_clr;
  logic             w_pre_hold;
  logic             w_tick;
  logic             w_terminal;

  // Prescaler only advances in RUN; a stop in RUN still lets that cycle count, then holds.
  assign w_pre_hold = (r_state != ST_RUN);

  counter_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_pre_clr),
    .i_hold (w_pre_hold),
    .o_tick (w_tick)
  );

  // The counter is never commanded past its end value in either direction.
  assign w_terminal = (r_cnt_mode == MODE_DOWN) ? (i_cnt_in == '0)
                                                : (i_cnt_in == {CNT_W{1'b1}});

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_en_nxt       = 1'b0;
    w_cnt_load_nxt     = 1'b0;
    w_tc_nxt           = 1'b0;
    w_cnt_mode_nxt     = r_cnt_mode;
    w_cnt_load_val_nxt = r_cnt_load_val;
    w_pre_clr          = 1'b0;

    // Direction toggles independently of the other buttons, except during the load cycle.
    if (i_btn_dir && (r_state != ST_LOAD)) begin
      w_cnt_mode_nxt = ~r_cnt_mode;
    end

    // Load has top priority wherever it is accepted; entering LOAD raises en+load together.
    if (i_btn_load && (r_state != ST_LOAD)) begin
      w_state_nxt        = ST_LOAD;
      w_cnt_load_val_nxt = i_load_val;
      w_cnt_en_nxt       = 1'b1;
      w_cnt_load_nxt     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_btn_start) begin
            w_state_nxt = ST_RUN;
            w_pre_clr   = 1'b1;
          end
        end
        ST_LOAD: begin
          w_state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (i_btn_stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_tick) begin
            if (w_terminal) begin
              w_tc_nxt = 1'b1;
`ifdef COUNTER_CTRL_BOUNCE_EN
              // Reverse unconditionally; overrides a coincident dir press.
              w_cnt_mode_nxt = ~r_cnt_mode;
`else
              w_state_nxt = ST_DONE;
`endif
            end else begin
              w_cnt_en_nxt = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (i_btn_stop) begin
            w_state_nxt = ST_IDLE;
          end else if (i_btn_start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          if (i_btn_start) begin
            w_state_nxt = ST_RUN;
            w_pre_clr   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_cnt_en       <= 1'b0;
      r_cnt_load     <= 1'b0;
      r_tc           <= 1'b0;
      r_cnt_mode     <= MODE_UP;
      r_cnt_load_val <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt_en       <= w_cnt_en_nxt;
      r_cnt_load     <= w_cnt_load_nxt;
      r_tc           <= w_tc_nxt;
      r_cnt_mode     <= w_cnt_mode_nxt;
      r_cnt_load_val <= w_cnt_load_val_nxt;
    end
  end

  assign o_cnt_en       = r_cnt_en;
  assign o_cnt_mode     = r_cnt_mode;
  assign o_cnt_load     = r_cnt_load;
  assign o_cnt_load_val = r_cnt_load_val;
  assign o_tc           = r_tc;
  assign o_state        = r_state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Purpose: self-checking bench for counter_seq_ctrl with a behavioural counter closing the loop.
// Latency: expected control events are queued ahead of stimulus and checked as the DUT emits them.
// Backpressure: n/a; every wait is bounded and a global watchdog ends a stuck run.
// Ports: none (top-level bench). Honours COUNTER_CTRL_BOUNCE_EN for the ping-pong scenario.
module tb_counter_seq_ctrl;
  import counter_pkg::*;

  localparam int CNT_W    = 4;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_start, btn_stop, btn_load, btn_dir;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt_in;
  logic             cnt_en, cnt_mode, cnt_load, tc;
  logic [CNT_W-1:0] cnt_load_val;
  logic [2:0]       state;

  always #5 clk = ~clk;

  counter_seq_ctrl #(
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_btn_start    (btn_start),
    .i_btn_stop     (btn_stop),
    .i_btn_load     (btn_load),
    .i_btn_dir      (btn_dir),
    .i_load_val     (load_val),
    .i_cnt_in       (cnt_in),
    .o_cnt_en       (cnt_en),
    .o_cnt_mode     (cnt_mode),
    .o_cnt_load     (cnt_load),
    .o_cnt_load_val (cnt_load_val),
    .o_tc           (tc),
    .o_state        (state)
  );

  // Counter datapath model driven by the controller outputs.
  always @(posedge clk) begin
    if (rst)                  cnt_in <= '0;
    else if (cnt_en && cnt_load) cnt_in <= cnt_load_val;
    else if (cnt_en)          cnt_in <= cnt_mode ? cnt_in + 4'd1 : cnt_in - 4'd1;
  end

  typedef struct packed {
    logic       en;
    logic       ld;
    logic       tc;
    logic       mode;
    logic [3:0] lval;
    logic [2:0] st;
    logic [3:0] cnt;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(logic en, logic ld, logic t, logic mode,
                             logic [3:0] lval, logic [2:0] st, logic [3:0] cnt);
    ev_t e;
    e = {en, ld, t, mode, lval, st, cnt};
    return e;
  endfunction

  // Monitor: every cycle with en, load or tc high must match the next queued event.
  always @(negedge clk) begin
    ev_t act;
    ev_t exp;
    if (!rst && (cnt_en || cnt_load || tc)) begin
      act = {cnt_en, cnt_load, tc, cnt_mode, cnt_load_val, state, cnt_in};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got en=%b ld=%b tc=%b mode=%b lval=%0d st=%0d cnt=%0d, none expected",
                 act.en, act.ld, act.tc, act.mode, act.lval, act.st, act.cnt);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL event got en=%b ld=%b tc=%b mode=%b lval=%0d st=%0d cnt=%0d exp en=%b ld=%b tc=%b mode=%b lval=%0d st=%0d cnt=%0d",
                   act.en, act.ld, act.tc, act.mode, act.lval, act.st, act.cnt,
                   exp.en, exp.ld, exp.tc, exp.mode, exp.lval, exp.st, exp.cnt);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic s, input logic p, input logic l, input logic d,
                       input logic [3:0] v);
    btn_start = s; btn_stop = p; btn_load = l; btn_dir = d; load_val = v;
    cyc(1);
    btn_start = 1'b0; btn_stop = 1'b0; btn_load = 1'b0; btn_dir = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d events pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, 8'(state), 8'(ST_IDLE));
    chk({tag, "_en"},    8'(cnt_en), 8'd0);
    chk({tag, "_load"},  8'(cnt_load), 8'd0);
    chk({tag, "_tc"},    8'(tc), 8'd0);
    chk({tag, "_mode"},  8'(cnt_mode), 8'd1);
    chk({tag, "_lval"},  8'(cnt_load_val), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_load = 1'b0; btn_dir = 1'b0;
    load_val = '0;
    cyc(2);
    do_reset();
    check_reset("rst0");

    // Count up from 0: steps every PRESCALE cycles, terminal at 15 -> DONE.
    for (int i = 0; i < 15; i++) sb.push_back(mk(1, 0, 0, 1, 0, ST_RUN, 4'(i)));
    sb.push_back(mk(0, 0, 1, 1, 0, ST_DONE, 15));
    press(1, 0, 0, 0, 0);
    drain("up_run", 100);
    cyc(12);
    chk("up_done_state", 8'(state), 8'(ST_DONE));
    chk("up_final_cnt", 8'(cnt_in), 8'd15);

    // Load 9 from IDLE: one-cycle LOAD with en+load, then IDLE.
    do_reset();
    sb.push_back(mk(1, 1, 0, 1, 9, ST_LOAD, 0));
    press(0, 0, 1, 0, 9);
    chk("load_lval", 8'(cnt_load_val), 8'd9);
    cyc(1);
    chk("load_back_idle", 8'(state), 8'(ST_IDLE));
    chk("load_cnt", 8'(cnt_in), 8'd9);
    drain("load", 4);

    // Count down from 2 after a dir toggle in IDLE.
    do_reset();
    sb.push_back(mk(1, 1, 0, 1, 2, ST_LOAD, 0));
    press(0, 0, 1, 0, 2);
    cyc(1);
    press(0, 0, 0, 1, 0);
    chk("dir_mode", 8'(cnt_mode), 8'd0);
    sb.push_back(mk(1, 0, 0, 0, 2, ST_RUN, 2));
    sb.push_back(mk(1, 0, 0, 0, 2, ST_RUN, 1));
    sb.push_back(mk(0, 0, 1, 0, 2, ST_DONE, 0));
    press(1, 0, 0, 0, 0);
    drain("down_run", 40);
    cyc(8);
    chk("down_done_state", 8'(state), 8'(ST_DONE));

    // Pause with prescaler at 2, resume: step arrives one cycle after the resume edge.
    do_reset();
    press(1, 0, 0, 0, 0);
    cyc(2);
    press(0, 1, 0, 0, 0);
    cyc(9);
    chk("pause_state", 8'(state), 8'(ST_PAUSE));
    sb.push_back(mk(1, 0, 0, 1, 0, ST_RUN, 0));
    press(1, 0, 0, 0, 0);
    chk("resume_edge_en", 8'(cnt_en), 8'd0);
    cyc(1);
    chk("resume_next_en", 8'(cnt_en), 8'd1);
    press(0, 1, 0, 0, 0);
    chk("stop_to_pause", 8'(state), 8'(ST_PAUSE));
    press(0, 1, 0, 0, 0);
    chk("stop_to_idle", 8'(state), 8'(ST_IDLE));
    drain("pause", 4);

    // load+stop+start together in RUN picks LOAD; reset during LOAD clears everything.
    do_reset();
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    sb.push_back(mk(1, 1, 0, 0, 5, ST_LOAD, 0));
    press(1, 1, 1, 0, 5);
    chk("prio_state", 8'(state), 8'(ST_LOAD));
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("rst_load");
    drain("prio", 2);

`ifdef COUNTER_CTRL_BOUNCE_EN
    // Ping-pong: up from 14, terminal at 15 reverses without leaving RUN.
    do_reset();
    sb.push_back(mk(1, 1, 0, 1, 14, ST_LOAD, 0));
    press(0, 0, 1, 0, 14);
    cyc(1);
    sb.push_back(mk(1, 0, 0, 1, 14, ST_RUN, 14));
    sb.push_back(mk(0, 0, 1, 0, 14, ST_RUN, 15));
    sb.push_back(mk(1, 0, 0, 0, 14, ST_RUN, 15));
    press(1, 0, 0, 0, 0);
    drain("bounce", 40);
    press(0, 1, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    chk("bounce_cnt", 8'(cnt_in), 8'd14);
    chk("bounce_idle", 8'(state), 8'(ST_IDLE));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
